// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, datapath selects and
// the control word passed from the output decoder to the top.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StError    = 4'd11
  } state_e;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;

  // ALUop encoding, also consumed by the ALU decoder
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  // fetch marks strobes that only fire once memory data is valid
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       fetch;
    logic       reg_write;
    logic       mem_write;
    logic       pc_update;
    logic       branch;
    logic       instr_done;
    logic       illegal;
  } ctrl_word_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OpSw:    return ImmS;
      OpBeq:   return ImmB;
      OpJal:   return ImmJ;
      default: return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decoder: Moore outputs per state plus op-derived imm_src.
module ctrl_out_decode
  import control_fsm_pkg::*;
(
  input  state_e     i_state,
  input  logic [6:0] i_op,
  output ctrl_word_t o_cw
);

  always_comb begin
    o_cw         = '0;
    o_cw.imm_src = imm_src_of(i_op);
    case (i_state)
      StFetch: begin
        o_cw.alu_src_b  = SrcBFour;
        o_cw.result_src = ResAluResult;
        o_cw.fetch      = 1'b1;
      end
      StDecode: begin
        o_cw.alu_src_a = SrcAOldPc;
        o_cw.alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        o_cw.alu_src_a = SrcARd1;
        o_cw.alu_src_b = SrcBImm;
      end
      StMemRead: o_cw.adr_src = 1'b1;
      StMemWb: begin
        o_cw.result_src = ResData;
        o_cw.reg_write  = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      StMemWrite: begin
        o_cw.adr_src    = 1'b1;
        o_cw.mem_write  = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      StExecR: begin
        o_cw.alu_src_a = SrcARd1;
        o_cw.alu_op    = AluFunct;
      end
      StExecI: begin
        o_cw.alu_src_a = SrcARd1;
        o_cw.alu_src_b = SrcBImm;
        o_cw.alu_op    = AluFunct;
      end
      StAluWb: begin
        o_cw.reg_write  = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      StBeq: begin
        o_cw.alu_src_a  = SrcARd1;
        o_cw.alu_op     = AluSub;
        o_cw.branch     = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      StJal: begin
        o_cw.alu_src_a = SrcAOldPc;
        o_cw.alu_src_b = SrcBFour;
        o_cw.pc_update = 1'b1;
      end
      StError: o_cw.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V main controller: state register, next-state logic and strobe gating
// around the combinational control-word decoder.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     r_state;
  state_e     w_state_d;
  ctrl_word_t w_cw;
  logic       w_run;
  logic       w_fetch_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StFetch:   if (mem_ready) w_state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpSw: w_state_d = StMemAdr;
          OpR:        w_state_d = StExecR;
          OpI:        w_state_d = StExecI;
          OpBeq:      w_state_d = StBeq;
          OpJal:      w_state_d = StJal;
          default:    w_state_d = HALT_ON_ILLEGAL ? StError : StFetch;
        endcase
      end
      StMemAdr:  w_state_d = (op == OpLw) ? StMemRead : StMemWrite;
      StMemRead: if (mem_ready) w_state_d = StMemWb;
      StMemWb, StMemWrite, StAluWb, StBeq: w_state_d = StFetch;
      StExecR, StExecI, StJal:             w_state_d = StAluWb;
      StError:   w_state_d = StError;
      default:   w_state_d = StFetch;
    endcase
  end

  ctrl_out_decode u_decode (
    .i_state (r_state),
    .i_op    (op),
    .o_cw    (w_cw)
  );

  // Reset masks every strobe, including the mem_ready-gated fetch strobes
  assign w_run      = ~reset;
  assign w_fetch_go = w_cw.fetch & mem_ready;

  assign alu_op     = w_cw.alu_op;
  assign alu_src_a  = w_cw.alu_src_a;
  assign alu_src_b  = w_cw.alu_src_b;
  assign result_src = w_cw.result_src;
  assign imm_src    = w_cw.imm_src;
  assign adr_src    = w_cw.adr_src;
  assign ir_write   = w_run & w_fetch_go;
  assign reg_write  = w_run & w_cw.reg_write;
  assign mem_write  = w_run & w_cw.mem_write;
  assign pc_write   = w_run & (w_cw.pc_update | w_fetch_go | (w_cw.branch & zero));
  assign instr_done = w_run & w_cw.instr_done;
  assign illegal    = w_cw.illegal;
  assign state      = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed scenarios plus randomized instruction
// streams compared against a per-instruction state-sequence and output-table model.
module tb_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = LW;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
  logic       adr_src, ir_write, reg_write, mem_write, pc_write, instr_done, illegal;
  logic [3:0] state;

  logic [1:0] nh_alu_op, nh_alu_src_a, nh_alu_src_b, nh_result_src, nh_imm_src;
  logic       nh_adr_src, nh_ir_write, nh_reg_write, nh_mem_write, nh_pc_write;
  logic       nh_instr_done, nh_illegal;
  logic [3:0] nh_state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  control_fsm #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .pc_write(pc_write),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  control_fsm #(.HALT_ON_ILLEGAL(1'b0)) u_dut_nh (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .alu_op(nh_alu_op), .alu_src_a(nh_alu_src_a), .alu_src_b(nh_alu_src_b),
    .result_src(nh_result_src), .imm_src(nh_imm_src), .adr_src(nh_adr_src),
    .ir_write(nh_ir_write), .reg_write(nh_reg_write), .mem_write(nh_mem_write),
    .pc_write(nh_pc_write), .instr_done(nh_instr_done), .illegal(nh_illegal),
    .state(nh_state)
  );

  wire [20:0] obs = {state, alu_op, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
                     ir_write, reg_write, mem_write, pc_write, instr_done, illegal};
  wire [20:0] nh_obs = {nh_state, nh_alu_op, nh_alu_src_a, nh_alu_src_b, nh_result_src,
                        nh_imm_src, nh_adr_src, nh_ir_write, nh_reg_write, nh_mem_write,
                        nh_pc_write, nh_instr_done, nh_illegal};

  // Expected outputs for a state, straight from the per-state output table
  function automatic logic [20:0] exp_vec(input logic [3:0] s, input logic [6:0] o,
                                          input logic mr, input logic z);
    logic [1:0] aop, sa, sb, rs, imm;
    logic       adr, irw, rw, mw, pw, dn, il;
    aop = (s == 4'd6 || s == 4'd7) ? 2'd2 : (s == 4'd9) ? 2'd1 : 2'd0;
    sa  = (s == 4'd2 || s == 4'd6 || s == 4'd7 || s == 4'd9) ? 2'd2 :
          (s == 4'd1 || s == 4'd10) ? 2'd1 : 2'd0;
    sb  = (s == 4'd0 || s == 4'd10) ? 2'd2 :
          (s == 4'd1 || s == 4'd2 || s == 4'd7) ? 2'd1 : 2'd0;
    rs  = (s == 4'd0) ? 2'd2 : (s == 4'd4) ? 2'd1 : 2'd0;
    imm = (o == SW) ? 2'd1 : (o == BEQ) ? 2'd2 : (o == JAL) ? 2'd3 : 2'd0;
    adr = (s == 4'd3 || s == 4'd5);
    irw = (s == 4'd0) && mr;
    rw  = (s == 4'd4 || s == 4'd8);
    mw  = (s == 4'd5);
    pw  = ((s == 4'd0) && mr) || (s == 4'd10) || ((s == 4'd9) && z);
    dn  = (s == 4'd4 || s == 4'd5 || s == 4'd8 || s == 4'd9);
    il  = (s == 4'd11);
    return {s, aop, sa, sb, rs, imm, adr, irw, rw, mw, pw, dn, il};
  endfunction

  function automatic int seq_len(input logic [6:0] o);
    case (o)
      LW:      return 5;
      BEQ:     return 3;
      default: return 4;
    endcase
  endfunction

  // k-th state visited by an instruction (k = 0 is FETCH)
  function automatic logic [3:0] seq_state(input logic [6:0] o, input int k);
    logic [3:0] s [5];
    case (o)
      LW:      s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      SW:      s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
      RT:      s = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
      IT:      s = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
      BEQ:     s = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
      default: s = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    endcase
    return s[k];
  endfunction

  function automatic logic [6:0] pick_op(input int i);
    case (i)
      0:       return LW;
      1:       return SW;
      2:       return RT;
      3:       return IT;
      4:       return BEQ;
      default: return JAL;
    endcase
  endfunction

  task automatic test_reset();
    logic [20:0] e;
    for (int i = 0; i < 4; i++) begin
      op = pick_op($urandom_range(0, 5));
      mem_ready = 1'b1;
      zero = 1'b1;
      #2;
      e = exp_vec(4'd0, op, 1'b0, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, obs, e);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [20:0] e;
    op = LW;
    mem_ready = 1'b1;
    for (int k = 0; k < seq_len(op); k++) begin
      zero = 1'($urandom);
      #2;
      e = exp_vec(seq_state(op, k), op, mem_ready, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL lw cycle %0d: got %h want %h", k + 1, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [20:0] e;
    op = BEQ;
    mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      for (int k = 0; k < seq_len(op); k++) begin
        zero = (k == 2) ? 1'(z) : 1'($urandom);
        #2;
        e = exp_vec(seq_state(op, k), op, mem_ready, zero);
        n_vec++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL beq zero=%0d cycle %0d: got %h want %h", z, k + 1, obs, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic [20:0] e;
    op = RT;
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b0;
      #2;
      e = exp_vec(4'd0, op, 1'b0, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL fetch_stall wait %0d: got %h want %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    for (int k = 0; k < seq_len(op); k++) begin
      #2;
      e = exp_vec(seq_state(op, k), op, mem_ready, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL fetch_stall cycle %0d: got %h want %h", k + 1, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e;
    logic [6:0]  prog [2];
    prog = '{RT, JAL};
    mem_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      op = prog[n];
      for (int k = 0; k < seq_len(op); k++) begin
        zero = 1'($urandom);
        #2;
        e = exp_vec(seq_state(op, k), op, mem_ready, zero);
        n_vec++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL b2b op=%b cycle %0d: got %h want %h", op, k + 1, obs, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_random();
    logic [20:0] e;
    logic [3:0]  st;
    int          ns;
    for (int n = 0; n < 60; n++) begin
      op = pick_op($urandom_range(0, 5));
      for (int k = 0; k < seq_len(op); k++) begin
        st = seq_state(op, k);
        ns = (st == 4'd0 || st == 4'd3) ? $urandom_range(0, 3) : 0;
        for (int w = 0; w < ns; w++) begin
          mem_ready = 1'b0;
          zero = 1'($urandom);
          #2;
          e = exp_vec(st, op, mem_ready, zero);
          n_vec++;
          if (obs !== e) begin
            n_bad++;
            $display("FAIL random stall op=%b st=%0d: got %h want %h", op, st, obs, e);
          end
          @(posedge clk); #1;
        end
        mem_ready = (st == 4'd0 || st == 4'd3) ? 1'b1 : 1'($urandom);
        zero = 1'($urandom);
        #2;
        e = exp_vec(st, op, mem_ready, zero);
        n_vec++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL random op=%b cycle %0d: got %h want %h", op, k + 1, obs, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e;
    op = SW;
    mem_ready = 1'b1;
    for (int k = 0; k < seq_len(op); k++) begin
      #2;
      e = exp_vec(seq_state(op, k), op, mem_ready, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset_mid cycle %0d: got %h want %h", k + 1, obs, e);
      end
      if (k == 3) begin
        reset = 1'b1;
        #1;
        e = exp_vec(4'd0, op, 1'b0, zero);
        n_vec++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL reset_mid async: got %h want %h", obs, e);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    #2;
    e = exp_vec(4'd0, op, 1'b0, zero);
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_mid release: got %h want %h", obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [20:0] e;
    op = BAD;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      e = exp_vec(k[3:0], op, mem_ready, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL illegal pre cycle %0d: got %h want %h", k + 1, obs, e);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      #2;
      e = exp_vec(4'd11, op, mem_ready, zero);
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL illegal park %0d: got %h want %h", i, obs, e);
      end
      if (i == 0) begin
        e = exp_vec(4'd0, op, mem_ready, zero);
        n_vec++;
        if (nh_obs !== e) begin
          n_bad++;
          $display("FAIL illegal no-halt: got %h want %h", nh_obs, e);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    e = exp_vec(4'd0, op, 1'b0, zero);
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL illegal reset: got %h want %h", obs, e);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b0;
    #2;
    e = exp_vec(4'd0, op, 1'b0, zero);
    n_vec++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL illegal after reset: got %h want %h", obs, e);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_lw();
    test_beq();
    test_fetch_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
